// File: rtl/mxreg_read_port_11_if.sv
// Read request / response stream bundle for the MX-11 register bank read port.
interface mxreg_read_port_11_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   rd_req;
  logic [7:0]             rd_addr;
  logic                   rd_ack;
  logic [WORD_LENGTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   rd_last;
  logic                   rd_err;

  modport master (
    output rd_req, rd_addr, rd_ready,
    input  rd_ack, rd_data, rd_valid, rd_last, rd_err
  );

  modport slave (
    input  rd_req, rd_addr, rd_ready,
    output rd_ack, rd_data, rd_valid, rd_last, rd_err
  );
endinterface

// File: rtl/mxreg_read_port_11.sv
// MX-11 register bank read port: address-mapped readback over a valid/ready stream.
// Optional MXREG_RD_PIPE_EN allows acceptance during the final beat (back-to-back responses).
module mxreg_read_port_11 #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DEPTH-1:0][WORD_LENGTH-1:0]   reg_line,
  mxreg_read_port_11_if.slave                 rd
);

  localparam int unsigned IDX_A     = 0;
  localparam int unsigned IDX_D     = 3;
  localparam int unsigned IDX_FLAGS = 7;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] w0_q, w1_q;
  logic                   two_q, err_q;

  logic [WORD_LENGTH-1:0] dec_w0, dec_w1;
  logic                   dec_two, dec_err;
  logic                   valid, last_beat, hs, ack, accept;

  always_comb begin
    dec_w0  = '0;
    dec_w1  = '0;
    dec_two = 1'b0;
    dec_err = 1'b0;
    if (rd.rd_addr[7:4] == 4'h0) begin
      dec_w0 = reg_line[rd.rd_addr[3:0]];
    end else if (rd.rd_addr == 8'h10) begin
      dec_w0  = reg_line[IDX_FLAGS];
      dec_w1  = reg_line[IDX_A];
      dec_two = 1'b1;
    end else if (rd.rd_addr == 8'h11) begin
      dec_w0  = reg_line[IDX_FLAGS];
      dec_w1  = reg_line[IDX_D];
      dec_two = 1'b1;
    end else begin
      dec_err = 1'b1;
    end
  end

  assign valid     = (state_q != IDLE);
  assign last_beat = ((state_q == BEAT0) && !two_q) || (state_q == BEAT1);
  assign hs        = valid && rd.rd_ready;

`ifdef MXREG_RD_PIPE_EN
  assign ack = !rst && ((state_q == IDLE) || (last_beat && rd.rd_ready));
`else
  assign ack = !rst && (state_q == IDLE);
`endif

  assign accept = rd.rd_req && ack;

  // accept can only be high in a beat state when the pipelined ack is built in
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = BEAT0;
      BEAT0: if (hs) state_d = two_q ? BEAT1 : (accept ? BEAT0 : IDLE);
      BEAT1: if (hs) state_d = accept ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        w0_q  <= dec_w0;
        w1_q  <= dec_w1;
        two_q <= dec_two;
        err_q <= dec_err;
      end
    end
  end

  assign rd.rd_ack   = ack;
  assign rd.rd_valid = valid;
  assign rd.rd_data  = (state_q == BEAT0) ? w0_q :
                       (state_q == BEAT1) ? w1_q : '0;
  assign rd.rd_last  = last_beat;
  assign rd.rd_err   = (state_q == BEAT0) && err_q;

endmodule
